// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable data memory: RISC-V func3
// encodings, access-size codes, FSM states and the access decoder.
package mem_pkg;

  // func3 encodings (loads use all of them, stores only B/H/W/D)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // access size codes: number of bytes is 1 << size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] size;
    logic       sext;
  } acc_dec_t;

  // Decode func3 into size/sign; 64-bit-only encodings are illegal on a 32-bit memory.
  function automatic acc_dec_t size_decode(input logic [2:0] func3,
                                           input logic       wr,
                                           input logic       dw64);
    acc_dec_t d;
    d.legal = 1'b0;
    d.size  = SZ_B;
    d.sext  = 1'b0;
    case (func3)
      F3_B:    begin d.legal = 1'b1;        d.size = SZ_B; d.sext = ~wr;  end
      F3_H:    begin d.legal = 1'b1;        d.size = SZ_H; d.sext = ~wr;  end
      F3_W:    begin d.legal = 1'b1;        d.size = SZ_W; d.sext = ~wr;  end
      F3_D:    begin d.legal = dw64;        d.size = SZ_D; d.sext = 1'b0; end
      F3_BU:   begin d.legal = ~wr;         d.size = SZ_B; d.sext = 1'b0; end
      F3_HU:   begin d.legal = ~wr;         d.size = SZ_H; d.sext = 1'b0; end
      F3_WU:   begin d.legal = ~wr & dw64;  d.size = SZ_W; d.sext = 1'b0; end
      default: begin d.legal = 1'b0;        d.size = SZ_B; d.sext = 1'b0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_lane_align.sv
// Combinational lane steering: store byte-enables and lane-shifted store data,
// plus load extraction with sign/zero extension to the full data width.
module data_lane_align
  import mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int NB = DW / 8,
  parameter int OW = $clog2(DW / 8)
) (
  input  logic [1:0]    size,
  input  logic [OW-1:0] offset,
  input  logic          sext,
  input  logic [DW-1:0] store_data,
  input  logic [DW-1:0] word_data,
  output logic [NB-1:0] byte_en,
  output logic [DW-1:0] store_lane,
  output logic [DW-1:0] load_data
);

  logic [NB-1:0] size_mask_s;
  logic [DW-1:0] word_shift_s;
  logic          sign_s;
  int            nbits_s;

  // Store path: enable the addressed bytes and move data into its lane.
  always_comb begin
    size_mask_s = {NB{1'b0}};
    case (size)
      SZ_B:    size_mask_s = NB'(4'h1);
      SZ_H:    size_mask_s = NB'(4'h3);
      SZ_W:    size_mask_s = NB'(4'hF);
      default: size_mask_s = {NB{1'b1}};
    endcase
    byte_en    = size_mask_s << offset;
    store_lane = store_data << {offset, 3'b000};
  end

  // Load path: right-align the addressed bytes, then extend above the access width.
  always_comb begin
    word_shift_s = word_data >> {offset, 3'b000};
    nbits_s      = DW;
    sign_s       = 1'b0;
    case (size)
      SZ_B:    begin nbits_s = 32'd8;  sign_s = word_shift_s[7];  end
      SZ_H:    begin nbits_s = 32'd16; sign_s = word_shift_s[15]; end
      SZ_W:    begin nbits_s = 32'd32; sign_s = word_shift_s[31]; end
      default: begin nbits_s = DW;     sign_s = 1'b0;             end
    endcase
    for (int i = 0; i < DW; i++) begin
      load_data[i] = (i < nbits_s) ? word_shift_s[i] : (sext & sign_s);
    end
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory with RISC-V load/store sizes, natural-alignment
// checking, optional wait states and a one-cycle response strobe.
module byte_data_memory
  import mem_pkg::*;
#(
  parameter int AW     = 13,
  parameter int DW     = 32,
  parameter int NUM_WS = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [2:0]    req_func3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  localparam int         NB        = DW / 8;
  localparam int         OW        = $clog2(NB);
  localparam int         NWORDS    = 2 ** (AW - OW);
  localparam bit         ZERO_WS   = (NUM_WS == 0);
  localparam int         WS_LAST_I = ZERO_WS ? 0 : NUM_WS - 1;
  localparam logic [1:0] WS_LAST   = 2'(WS_LAST_I);
  localparam logic       DW64      = (DW == 64);

  state_e           state_r, state_nxt_s;
  logic [1:0]       cnt_r, cnt_nxt_s;
  logic             accept_s, commit_s;

  logic             wr_r;
  logic [2:0]       func3_r;
  logic [AW-1:0]    addr_r;
  logic [DW-1:0]    wdata_r;

  logic             op_wr_s;
  logic [2:0]       op_func3_s;
  logic [AW-1:0]    op_addr_s;
  logic [DW-1:0]    op_wdata_s;
  acc_dec_t         dec_s;
  logic [OW-1:0]    op_off_s;
  logic [AW-OW-1:0] op_idx_s;
  logic [OW-1:0]    align_mask_s;
  logic             bad_s;
  logic [DW-1:0]    word_rd_s;

  logic [NB-1:0]    be_s;
  logic [DW-1:0]    lane_wdata_s;
  logic [DW-1:0]    load_data_s;

  logic [DW-1:0]    mem_r [NWORDS];
  logic [DW-1:0]    rsp_rdata_r;
  logic             rsp_err_r;

  assign req_ready = (state_r != WAIT);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign accept_s  = req_valid & req_ready;

  // Memory access happens on the edge that enters RESP: the accept edge itself
  // with no wait states, otherwise the last WAIT cycle.
  assign commit_s = ZERO_WS ? accept_s : ((state_r == WAIT) && (cnt_r == WS_LAST));

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        cnt_nxt_s = 2'd0;
        if (accept_s) begin
          if (ZERO_WS) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == WS_LAST) begin
          state_nxt_s = RESP;
          cnt_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = cnt_r + 2'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Hold the accepted request for the duration of the wait states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r    <= 1'b0;
      func3_r <= 3'b000;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
    end else if (accept_s) begin
      wr_r    <= req_wr;
      func3_r <= req_func3;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end
  end

  // Select the operands of the committing access and check size/alignment.
  always_comb begin
    op_wr_s    = ZERO_WS ? req_wr    : wr_r;
    op_func3_s = ZERO_WS ? req_func3 : func3_r;
    op_addr_s  = ZERO_WS ? req_addr  : addr_r;
    op_wdata_s = ZERO_WS ? req_wdata : wdata_r;
    dec_s      = size_decode(op_func3_s, op_wr_s, DW64);
    op_off_s   = op_addr_s[OW-1:0];
    op_idx_s   = op_addr_s[AW-1:OW];
    case (dec_s.size)
      SZ_B:    align_mask_s = {OW{1'b0}};
      SZ_H:    align_mask_s = OW'(3'd1);
      SZ_W:    align_mask_s = OW'(3'd3);
      default: align_mask_s = OW'(3'd7);
    endcase
    bad_s     = ~dec_s.legal | (|(op_off_s & align_mask_s));
    word_rd_s = mem_r[op_idx_s];
  end

  data_lane_align #(
    .DW (DW),
    .NB (NB),
    .OW (OW)
  ) u_align (
    .size       (dec_s.size),
    .offset     (op_off_s),
    .sext       (dec_s.sext),
    .store_data (op_wdata_s),
    .word_data  (word_rd_s),
    .byte_en    (be_s),
    .store_lane (lane_wdata_s),
    .load_data  (load_data_s)
  );

  // Byte-lane write-enabled storage; contents survive reset, and nothing is
  // written while reset is asserted.
  always_ff @(posedge clk) begin
    if (commit_s && rst_n && op_wr_s && !bad_s) begin
      for (int i = 0; i < NB; i++) begin
        if (be_s[i]) begin
          mem_r[op_idx_s][8*i +: 8] <= lane_wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Response data/error, sampled at commit and held until the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_r <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (commit_s) begin
      rsp_err_r   <= bad_s;
      rsp_rdata_r <= (bad_s || op_wr_s) ? {DW{1'b0}} : load_data_s;
    end
  end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 The module SHALL have parameter AW, default 13, meaning byte-address width.
REQ-002 The module SHALL have parameter DW, default 32, meaning data width; legal values are 32 and 64.
REQ-003 The module SHALL have parameter NUM_WS, default 0, meaning added wait states per access; legal range is 0..3.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The module SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 The module SHALL have port req_wr, input, 1 bit: 1 selects store, 0 selects load.
REQ-009 The module SHALL have port req_func3, input, 3 bits: RISC-V width/sign code.
REQ-010 The module SHALL have port req_addr, input, AW bits: byte address.
REQ-011 The module SHALL have port req_wdata, input, DW bits: store data, right-aligned.
REQ-012 The module SHALL have port rsp_valid, output, 1 bit: one-cycle response strobe.
REQ-013 The module SHALL have port rsp_rdata, output, DW bits: load result, already extended.
REQ-014 The module SHALL have port rsp_err, output, 1 bit: misaligned or illegal access.

Function
REQ-015 Storage SHALL be 2**AW/(DW/8) words of DW bits; word index = req_addr[AW-1:log2(DW/8)]; lane offset = the low log2(DW/8) bits.
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; inputs are captured at that edge.
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP: accept moves IDLE or RESP to WAIT if NUM_WS>0, else to RESP; WAIT counts NUM_WS cycles then moves to RESP; RESP moves to IDLE when no new accept.
REQ-018 req_ready SHALL be 1 in IDLE and RESP and 0 in WAIT.
REQ-019 rsp_valid SHALL be 1 exactly in RESP, i.e. 1+NUM_WS cycles after accept; with NUM_WS=0, back-to-back requests SHALL yield one response per cycle.
REQ-020 There SHALL be no response backpressure.
REQ-021 Legal func3 SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 LWU, 011 LD; stores 000 SB, 001 SH, 010 SW, 011 SD.
REQ-022 Encodings 011 and 110 SHALL be legal only when DW=64.
REQ-023 Alignment SHALL be natural: half-word requires addr[0]=0, word requires addr[1:0]=0, double requires addr[2:0]=0.
REQ-024 A misaligned or illegal access SHALL give rsp_err=1 and rsp_rdata=0, and memory SHALL be unchanged.
REQ-025 A store SHALL write only the addressed bytes: byte enables derive from size and lane offset; data is shifted into its lane; other bytes of the word are unchanged.
REQ-026 A load SHALL take the addressed bytes, right-align them, and sign- or zero-extend them to DW per func3.
REQ-027 Memory write and read sampling SHALL both occur at the edge entering RESP, so a load accepted after a store sees the stored data.
REQ-028 A store response SHALL have rsp_valid=1 and rsp_rdata=0.
REQ-029 rsp_rdata and rsp_err SHALL hold their value outside RESP, and consumers SHALL qualify them with rsp_valid.

Reset
REQ-030 rst_n=0 SHALL force state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and req_ready=1 after release.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset mid-operation SHALL drop the pending access; a store not yet committed SHALL NOT modify memory, and no response SHALL be issued for it.

Structure
REQ-033 Package mem_pkg SHALL hold the func3 encodings as typed constants, the FSM state enum, and the size-decode function.
REQ-034 The module SHALL contain one combinational sub-module, data_lane_align, which produces store byte-enables and shifted data plus load extract/extend.
REQ-035 The storage array SHALL be a per-byte-lane write-enabled array in a single always_ff block.

Verification
REQ-036 DW=32, NUM_WS=0: SW 0xDEADBEEF @0x10, then LB @0x13 -> response next cycle, rdata=0xFFFFFFDE, err=0; LBU @0x13 -> 0x000000DE.
REQ-037 SW 0x11223344 @0x20, SB 0xAA @0x21, LW @0x20 -> 0x1122AA44; SH 0x8001 @0x22, LH @0x22 -> 0xFFFF8001.
REQ-038 LW @0x22 and SH @0x23 -> err=1, rdata=0; a following LW @0x20 is unchanged; func3=111 -> err=1.
REQ-039 NUM_WS=2: accept at cycle 0 -> req_ready=0 in cycles 1-2, rsp_valid only in cycle 3; with req_valid held high, the next accept is in cycle 3.
REQ-040 DW=64: SD 0x0123456789ABCDEF @0x8, LWU @0xC -> 0x0000000001234567, LD @0x8 -> full value; LD @0x4 -> err=1.
REQ-041 NUM_WS=3: SW 0x55 @0x0 accepted, rst_n pulsed low in cycle 2 -> no rsp_valid; LW @0x0 after reset returns the prior contents.
